// File: rtl/crc8_checker.sv
// crc8_checker: receive-side CRC-8 checker; strips the trailer byte and tags each packet's
// last payload byte with pass/fail. Optional saturating error counter: CRC_CHK_ERR_CNT_EN.
module crc8_checker #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    input  logic             in_sop,
    input  logic             in_eop,
    output logic             in_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    output logic             out_sop,
    output logic             out_eop,
    output logic             out_crc_err,
`ifdef CRC_CHK_ERR_CNT_EN
    output logic [CNT_W-1:0] err_cnt,
    input  logic             err_cnt_clr,
`endif
    input  logic             out_ready
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } state_t;

    // One byte-wide step of the x^8+x^7+x^6+x^3+x^2+x+1 CRC.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] x;
        logic [7:0] n;
        x    = crc ^ data;
        n[0] = x[0] ^ x[1] ^ x[3] ^ x[4] ^ x[5] ^ x[7];
        n[1] = x[0] ^ x[2] ^ x[3] ^ x[6] ^ x[7];
        n[2] = x[0] ^ x[5];
        n[3] = x[0] ^ x[3] ^ x[4] ^ x[5] ^ x[6] ^ x[7];
        n[4] = x[1] ^ x[4] ^ x[5] ^ x[6] ^ x[7];
        n[5] = x[2] ^ x[5] ^ x[6] ^ x[7];
        n[6] = x[0] ^ x[1] ^ x[4] ^ x[5] ^ x[6];
        n[7] = x[0] ^ x[2] ^ x[3] ^ x[4] ^ x[6];
        return n;
    endfunction

    state_t     state_r, state_s;
    logic [7:0] crc_r, crc_s;
    logic [7:0] hold_data_r, hold_data_s;
    logic       hold_sop_r, hold_sop_s;
    logic       hold_vld_r, hold_vld_s;
    logic [7:0] out_data_r;
    logic       out_valid_r, out_sop_r, out_eop_r, out_crc_err_r;
    logic       load_s, ld_sop_s, ld_eop_s, ld_err_s;
    logic       accept_s, in_ready_s;
    logic [7:0] step_s;
    logic       crc_bad_s;

    assign in_ready_s  = !out_valid_r || out_ready;
    assign accept_s    = in_valid && in_ready_s;
    // An SOP byte always restarts the CRC, even when it truncates a packet in flight.
    assign step_s      = crc8_step(in_sop ? 8'hFF : crc_r, in_data);
    assign crc_bad_s   = (step_s != 8'h00);

    assign in_ready    = in_ready_s;
    assign out_data    = out_data_r;
    assign out_valid   = out_valid_r;
    assign out_sop     = out_sop_r;
    assign out_eop     = out_eop_r;
    assign out_crc_err = out_crc_err_r;

    // Next-state, CRC, holdback and output-load decode.
    always_comb begin
        state_s     = state_r;
        crc_s       = crc_r;
        hold_data_s = hold_data_r;
        hold_sop_s  = hold_sop_r;
        hold_vld_s  = hold_vld_r;
        load_s      = 1'b0;
        ld_sop_s    = 1'b0;
        ld_eop_s    = 1'b0;
        ld_err_s    = 1'b0;
        if (accept_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (in_sop && !in_eop) begin
                        crc_s       = step_s;
                        hold_data_s = in_data;
                        hold_sop_s  = 1'b1;
                        hold_vld_s  = 1'b1;
                        state_s     = ST_PKT;
                    end else begin
                        crc_s       = 8'hFF;
                    end
                end
                ST_PKT: begin
                    load_s   = hold_vld_r;
                    ld_sop_s = hold_sop_r;
                    if (in_sop) begin
                        ld_eop_s = 1'b1;
                        ld_err_s = 1'b1;
                        if (in_eop) begin
                            crc_s      = 8'hFF;
                            hold_vld_s = 1'b0;
                            state_s    = ST_IDLE;
                        end else begin
                            crc_s       = step_s;
                            hold_data_s = in_data;
                            hold_sop_s  = 1'b1;
                            hold_vld_s  = 1'b1;
                        end
                    end else if (in_eop) begin
                        ld_eop_s   = 1'b1;
                        ld_err_s   = crc_bad_s;
                        crc_s      = 8'hFF;
                        hold_vld_s = 1'b0;
                        state_s    = ST_IDLE;
                    end else begin
                        crc_s       = step_s;
                        hold_data_s = in_data;
                        hold_sop_s  = 1'b0;
                    end
                end
                default: begin
                    crc_s      = 8'hFF;
                    hold_vld_s = 1'b0;
                    state_s    = ST_IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Packet-tracking state, running CRC and the one-byte holdback register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            crc_r       <= 8'hFF;
            hold_data_r <= 8'h00;
            hold_sop_r  <= 1'b0;
            hold_vld_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            crc_r       <= crc_s;
            hold_data_r <= hold_data_s;
            hold_sop_r  <= hold_sop_s;
            hold_vld_r  <= hold_vld_s;
        end
    end

    // Single-entry output register; a load and a transfer together keep it full.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_r    <= 8'h00;
            out_valid_r   <= 1'b0;
            out_sop_r     <= 1'b0;
            out_eop_r     <= 1'b0;
            out_crc_err_r <= 1'b0;
        end else if (load_s) begin
            out_data_r    <= hold_data_r;
            out_valid_r   <= 1'b1;
            out_sop_r     <= ld_sop_s;
            out_eop_r     <= ld_eop_s;
            out_crc_err_r <= ld_err_s;
        end else if (out_valid_r && out_ready) begin
            out_valid_r   <= 1'b0;
        end else begin
            out_valid_r   <= out_valid_r;
        end
    end

`ifdef CRC_CHK_ERR_CNT_EN
    logic [1:0]       err_inc_s;
    logic [CNT_W:0]   err_sum_s;
    logic [CNT_W-1:0] err_cnt_r;

    assign err_sum_s = {1'b0, err_cnt_r} + (CNT_W+1)'(err_inc_s);
    assign err_cnt   = err_cnt_r;

    // A truncating SOP that is itself a runt counts twice: once per lost packet.
    always_comb begin
        err_inc_s = 2'd0;
        if (accept_s) begin
            if (state_r == ST_PKT && hold_vld_r && (in_sop || (in_eop && crc_bad_s))) begin
                err_inc_s = 2'd1;
            end else begin
                err_inc_s = 2'd0;
            end
            if (in_sop && in_eop) begin
                err_inc_s = err_inc_s + 2'd1;
            end else begin
                err_inc_s = err_inc_s;
            end
        end else begin
            err_inc_s = 2'd0;
        end
    end

    // Saturating error counter; clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_r <= {CNT_W{1'b0}};
        end else if (err_cnt_clr) begin
            err_cnt_r <= {CNT_W{1'b0}};
        end else if (err_sum_s[CNT_W]) begin
            err_cnt_r <= {CNT_W{1'b1}};
        end else begin
            err_cnt_r <= err_sum_s[CNT_W-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_crc8_checker.sv
// tb_crc8_checker: randomized and directed checks of crc8_checker against a packet-level
// reference model (bitwise long-division CRC, per-packet beat expansion).
module tb_crc8_checker;

    localparam int CNT_W = 4;
`ifdef CRC_CHK_ERR_CNT_EN
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    logic [CNT_W-1:0] err_cnt;
    logic             err_cnt_clr = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid, out_sop, out_eop, out_crc_err;
    logic       out_ready = 1'b1;

    int n_checks = 0;
    int n_fails  = 0;
    int rdy_mode = 0;
    int rdy_viol = 0;
    logic [1:0] tog_cnt = 2'd0;

    logic [10:0] obs_q[$];
    logic [10:0] exp_q[$];
    logic [7:0]  cur_pkt[$];
    bit          in_pkt = 1'b0;
    int          exp_err = 0;

    always #5 clk = ~clk;

    crc8_checker #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
        .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
        .out_crc_err(out_crc_err),
`ifdef CRC_CHK_ERR_CNT_EN
        .err_cnt(err_cnt), .err_cnt_clr(err_cnt_clr),
`endif
        .out_ready(out_ready)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference CRC: MSB-first polynomial long division, register preset to 0xFF.
    function automatic logic [7:0] crc_of(input logic [7:0] q[$]);
        logic [7:0] c;
        c = 8'hFF;
        foreach (q[i]) begin
            c = c ^ q[i];
            for (int b = 0; b < 8; b++) c = c[7] ? ((c << 1) ^ 8'hCF) : (c << 1);
        end
        return c;
    endfunction

    function automatic void count_err();
`ifdef CRC_CHK_ERR_CNT_EN
        if (exp_err < CNT_MAX) exp_err++;
`else
        exp_err++;
`endif
    endfunction

    function automatic void emit(input logic [7:0] q[$], input bit err);
        foreach (q[i]) begin
            bit last;
            last = (i == q.size() - 1);
            exp_q.push_back({last && err, last, i == 0, q[i]});
        end
    endfunction

    // Packet-level model fed with every accepted input byte.
    function automatic void model_accept(input logic [7:0] d, input bit sop, input bit eop);
        logic [7:0] pl[$];
        logic [7:0] c;
        if (sop) begin
            if (in_pkt) begin
                emit(cur_pkt, 1'b1);
                count_err();
                in_pkt = 1'b0;
            end
            if (eop) begin
                count_err();
            end else begin
                cur_pkt.delete();
                cur_pkt.push_back(d);
                in_pkt = 1'b1;
            end
        end else if (in_pkt) begin
            cur_pkt.push_back(d);
            if (eop) begin
                c  = crc_of(cur_pkt);
                pl = cur_pkt[0:cur_pkt.size()-2];
                emit(pl, c != 8'h00);
                if (c != 8'h00) count_err();
                in_pkt = 1'b0;
            end
        end
    endfunction

    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: begin
                tog_cnt   = tog_cnt + 2'd1;
                out_ready = tog_cnt[1];
            end
        endcase
    end

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) obs_q.push_back({out_crc_err, out_eop, out_sop, out_data});
        if (rst_n && (in_ready !== (!out_valid || out_ready))) rdy_viol++;
    end

    task automatic send(input logic [7:0] d, input bit sop, input bit eop);
        int w;
        w = 0;
        in_data = d; in_sop = sop; in_eop = eop; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            w++;
            @(negedge clk);
        end
        if (in_ready) model_accept(d, sop, eop);
        else check_eq("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] pl[$], input logic [7:0] corrupt);
        foreach (pl[i]) send(pl[i], i == 0, 1'b0);
        send(crc_of(pl) ^ corrupt, 1'b0, 1'b1);
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while ((obs_q.size() < exp_q.size() || out_valid) && t < 500) begin
            @(negedge clk);
            t++;
        end
        check_eq({tag, "_nbeats"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            check_eq({tag, "_beat"}, {21'd0, obs_q[i]}, {21'd0, exp_q[i]});
`ifdef CRC_CHK_ERR_CNT_EN
        check_eq({tag, "_err_cnt"}, {28'd0, err_cnt}, exp_err);
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] pl[$];
        int kind, len;

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_out_flags", {out_data, out_sop, out_eop, out_crc_err}, 11'd0);
        check_eq("rst_in_ready", in_ready, 1'b1);
`ifdef CRC_CHK_ERR_CNT_EN
        check_eq("rst_err_cnt", err_cnt, 0);
`endif
        @(posedge clk);
        #1;

        // Good and bad single-byte packets.
        send(8'h00, 1'b1, 1'b0); send(8'hD2, 1'b0, 1'b1);
        drain("good");
        check_eq("good_nbeats_lit", obs_q.size(), 1);
        if (obs_q.size() > 0) check_eq("good_beat_lit", obs_q[0], 11'h300);
        flush();
        send(8'h00, 1'b1, 1'b0); send(8'hD3, 1'b0, 1'b1);
        drain("bad");
        if (obs_q.size() > 0) check_eq("bad_beat_lit", obs_q[0], 11'h700);
        flush();

        // Backpressure on a 6-byte good packet.
        rdy_mode = 2;
        pl.delete();
        for (int i = 0; i < 5; i++) pl.push_back(8'($urandom));
        send_pkt(pl, 8'h00);
        drain("bp");
        check_eq("bp_nbeats_lit", obs_q.size(), 5);
        check_eq("bp_in_ready_rule", rdy_viol, 0);
        flush();
        rdy_mode = 0;

        // Runt followed by orphan bytes.
        send(8'h55, 1'b1, 1'b1); send(8'h11, 1'b0, 1'b0); send(8'h22, 1'b0, 1'b0);
        drain("runt");
        check_eq("runt_nbeats_lit", obs_q.size(), 0);
        flush();

        // Truncated packet followed by a good one.
        send(8'hA1, 1'b1, 1'b0); send(8'hA2, 1'b0, 1'b0);
        send(8'h00, 1'b1, 1'b0); send(8'hD2, 1'b0, 1'b1);
        drain("trunc");
        check_eq("trunc_nbeats_lit", obs_q.size(), 3);
        if (obs_q.size() == 3) begin
            check_eq("trunc_b0_lit", obs_q[0], 11'h1A1);
            check_eq("trunc_b1_lit", obs_q[1], 11'h6A2);
            check_eq("trunc_b2_lit", obs_q[2], 11'h300);
        end
        flush();

        // Reset in the middle of a packet.
        send(8'h00, 1'b1, 1'b0); send(8'h11, 1'b0, 1'b0); send(8'h22, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        cur_pkt.delete(); in_pkt = 1'b0; exp_err = 0;
        @(negedge clk);
        check_eq("mid_rst_outputs", {out_valid, out_data, out_sop, out_eop, out_crc_err}, 12'd0);
        check_eq("mid_rst_in_ready", in_ready, 1'b1);
        flush();
        @(posedge clk);
        #1;
        send(8'h00, 1'b1, 1'b0); send(8'hD2, 1'b0, 1'b1);
        drain("post_rst");
        if (obs_q.size() > 0) check_eq("post_rst_beat_lit", obs_q[0], 11'h300);
        flush();

`ifdef CRC_CHK_ERR_CNT_EN
        // Saturation, clear, and clear winning over a simultaneous increment.
        for (int i = 0; i < CNT_MAX + 3; i++) begin
            send(8'h00, 1'b1, 1'b0); send(8'hD3, 1'b0, 1'b1);
        end
        drain("sat");
        check_eq("sat_lit", err_cnt, CNT_MAX);
        flush();
        send(8'h00, 1'b1, 1'b0);
        err_cnt_clr = 1'b1;
        send(8'hD3, 1'b0, 1'b1);
        err_cnt_clr = 1'b0;
        exp_err = 0;
        drain("clr");
        flush();
`endif

        // Random mix: good, bad, runts, orphans, truncations; random backpressure.
        rdy_mode = 1;
        for (int p = 0; p < 60; p++) begin
            kind = (p == 59) ? 0 : $urandom_range(0, 4);
            len  = $urandom_range(1, 7);
            pl.delete();
            for (int j = 0; j < len; j++) pl.push_back(8'($urandom));
            case (kind)
                0: send_pkt(pl, 8'h00);
                1: send_pkt(pl, 8'($urandom_range(1, 255)));
                2: send(8'($urandom), 1'b1, 1'b1);
                3: begin send(8'($urandom), 1'b0, 1'b0); send(8'($urandom), 1'b0, 1'b0); end
                default: foreach (pl[j]) send(pl[j], j == 0, 1'b0);
            endcase
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        drain("rand");
        check_eq("rand_in_ready_rule", rdy_viol, 0);
        flush();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
